convolution_coprocessor_idx_seq: RTL
====================================

Name: convolution_coprocessor_idx_seq

Overview:
Index sequencer for the convolution coprocessor. It sits directly upstream of the index subtractor. For y[i] = sum over k of x[k]*h[i-k], it drives the output index i and the tap index k into the subtractor and takes back the difference j = i-k. It then issues one {k, j, i} address triple per cycle, with a valid/ready handshake, to the memory-read/MAC stage.

Parameters:
DATA_WIDTH, 5, width of every index, size and address bus; must equal the subtractor's DATA_WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle request to begin a convolution; honoured only in IDLE
size_x  input  DATA_WIDTH  length of x; sampled on accepted start
size_y  input  DATA_WIDTH  length of h; sampled on accepted start
sub_a  output  DATA_WIDTH  registered i; connects to subtractor re_A
sub_b  output  DATA_WIDTH  registered k; connects to subtractor re_B
sub_diff  input  DATA_WIDTH  subtractor re_out, equal to (i-k) mod 2^DATA_WIDTH
addr_x  output  DATA_WIDTH  x address (= k)
addr_y  output  DATA_WIDTH  h address (= sub_diff, combinational passthrough)
addr_z  output  DATA_WIDTH  output address (= i)
term_en  output  1  1 when the term is real: i>=k AND sub_diff<size_y; MAC adds zero when 0
mac_valid  output  1  triple on addr_* is valid
mac_ready  input  1  downstream accepts the triple
mac_first  output  1  first term of output i (k==0); MAC clears its accumulator
mac_last  output  1  last term of output i (k==size_x-1); MAC writes y[i]
busy  output  1  high in RUN
done  output  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; i, k, latched sizes all 0.
- Output values during reset: mac_valid=0, busy=0, done=0, sub_a=0, sub_b=0.
- Output length is Z = size_x + size_y - 1.
- Width rule: the caller guarantees size_x + size_y - 2 <= 2^DATA_WIDTH - 1, so Z-1 always fits in DATA_WIDTH.
- Size registers are unsigned. The i>=k test compares i and k directly and does not use the sign bit of sub_diff, because sub_diff wraps when i<k.
- State IDLE:
  - start=1 with both sizes nonzero: latch sizes, set i=0, k=0, go to RUN next cycle.
  - start=1 with either size 0: go to DONE with no term issued.
- State RUN:
  - busy=1 and mac_valid=1 every cycle.
  - On a handshake (mac_valid & mac_ready):
    - If k < size_x-1: k++.
    - Otherwise: k=0 and i++.
    - If k==size_x-1 and i==Z-1: go to DONE.
  - With no handshake, all outputs and registers hold.
- State DONE: done=1 for exactly one cycle, mac_valid=0, then IDLE.
- First valid triple appears on the cycle after start is accepted (one-cycle latency). Throughput is one term per cycle while mac_ready=1.
- Term count is always Z*size_x. The number of term_en=1 terms equals size_x*size_y.
- start while in RUN or DONE is ignored. Size inputs may change freely after they are latched.
- mac_ready is ignored outside RUN.
- rst asserted mid-operation aborts immediately to IDLE with no done pulse.
- addr_y depends combinationally on sub_a/sub_b through the subtractor. It is stable whenever sub_a/sub_b are stable.

Test Plan:
- Basic case: size_x=3, size_y=2, start, mac_ready=1.
  - Required: exactly 12 triples (i,k) = (0,0),(0,1),...,(3,2).
  - term_en sequence = 1,0,0, 1,1,0, 0,1,1, 0,0,1.
  - addr_y on enabled terms = 0,1,0,1,0,1.
  - mac_first on k=0; mac_last on k=2.
  - done pulses one cycle after the 12th handshake.
- Backpressure: same sizes, mac_ready toggling 1,0,0,1,...
  - Required: triples hold unchanged during ready=0.
  - Sequence and term_en are identical to the basic case; still 12 handshakes total.
- Zero size: size_x=0, size_y=4, start.
  - Required: mac_valid is never asserted; done pulses on the cycle after start; busy stays 0.
- Start during operation: start pulsed during RUN with size_x=1, size_y=1.
  - Required: ignored; the original sequence completes unchanged.
  - A later start in IDLE produces a single triple (0,0,0) with term_en=1, mac_first=1, mac_last=1.
- Reset mid-operation: assert rst after 5 handshakes.
  - Required: mac_valid=0, busy=0, sub_a=sub_b=0 asynchronously; no done pulse.
  - A following start runs a full fresh sequence.
- Maximum width: size_x=16, size_y=16 (Z=31).
  - Required: 496 triples; final i=30.
  - For i<k, sub_diff wraps (e.g. i=0,k=1 gives 31) and term_en=0.
  - Exactly 256 terms with term_en=1.

Source files
------------

// File: rtl/convolution_coprocessor_idx_seq_if.sv
// Address-triple bus between the index sequencer and the memory-read/MAC stage.
// The sequencer is the master; the MAC stage answers with mac_ready.
interface convolution_coprocessor_idx_seq_if #(
    parameter int DATA_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] addr_x;
    logic [DATA_WIDTH-1:0] addr_y;
    logic [DATA_WIDTH-1:0] addr_z;
    logic                  term_en;
    logic                  mac_valid;
    logic                  mac_ready;
    logic                  mac_first;
    logic                  mac_last;

    modport master (
        output addr_x, addr_y, addr_z, term_en, mac_valid, mac_first, mac_last,
        input  mac_ready
    );

    modport slave (
        input  addr_x, addr_y, addr_z, term_en, mac_valid, mac_first, mac_last,
        output mac_ready
    );
endinterface

// File: rtl/convolution_coprocessor_idx_seq.sv
// Index sequencer for the convolution coprocessor: walks (i, k) over all output
// and tap indices and issues one {k, i-k, i} address triple per handshake.
module convolution_coprocessor_idx_seq #(
    parameter int DATA_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] size_x,
    input  logic [DATA_WIDTH-1:0] size_y,
    output logic [DATA_WIDTH-1:0] sub_a,
    output logic [DATA_WIDTH-1:0] sub_b,
    input  logic [DATA_WIDTH-1:0] sub_diff,
    output logic                  busy,
    output logic                  done,
    convolution_coprocessor_idx_seq_if.master mac
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] TWO = DATA_WIDTH'(2);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] i_q, i_d;
    logic [DATA_WIDTH-1:0] k_q, k_d;
    logic [DATA_WIDTH-1:0] size_x_q, size_x_d;
    logic [DATA_WIDTH-1:0] size_y_q, size_y_d;
    logic [DATA_WIDTH-1:0] k_last;
    logic [DATA_WIDTH-1:0] i_last;
    logic                  handshake;

    // The caller keeps size_x + size_y - 2 within DATA_WIDTH, so no carry is lost.
    assign k_last    = size_x_q - ONE;
    assign i_last    = size_x_q + size_y_q - TWO;
    assign handshake = (state_q == RUN) && mac.mac_ready;

    // NOTE: every always_comb output takes its hold value first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        k_d      = k_q;
        size_x_d = size_x_q;
        size_y_d = size_y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_x != '0 && size_y != '0) begin
                        size_x_d = size_x;
                        size_y_d = size_y;
                        i_d      = '0;
                        k_d      = '0;
                        state_d  = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (handshake) begin
                    if (k_q != k_last) begin
                        k_d = k_q + ONE;
                    end else if (i_q == i_last) begin
                        i_d     = '0;
                        k_d     = '0;
                        state_d = DONE;
                    end else begin
                        k_d = '0;
                        i_d = i_q + ONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            i_q      <= '0;
            k_q      <= '0;
            size_x_q <= '0;
            size_y_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            k_q      <= k_d;
            size_x_q <= size_x_d;
            size_y_q <= size_y_d;
        end
    end

    assign sub_a = i_q;
    assign sub_b = k_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

    // i >= k is compared on the indices themselves because sub_diff wraps when i < k.
    assign mac.addr_x    = k_q;
    assign mac.addr_y    = sub_diff;
    assign mac.addr_z    = i_q;
    assign mac.term_en   = (i_q >= k_q) && (sub_diff < size_y_q);
    assign mac.mac_valid = (state_q == RUN);
    assign mac.mac_first = (k_q == '0);
    assign mac.mac_last  = (k_q == k_last);
endmodule
